// File: rtl/fetch_stage.sv
// Instruction fetch stage: pc sequencing against a synchronous ROM,
// a one-entry skid buffer for decode back-pressure, and redirect flush.
module fetch_stage #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic [31:0]       imem_q,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic              valid_out
);

    logic [31:0] pc_q, pc_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        valid_q, valid_d;
    logic        issue;

    assign imem_addr = pc_q[ADDR_W-1:0];
    assign instr_out = instr_q;
    assign pc_out    = opc_q;
    assign valid_out = valid_q;

    // A new fetch is only launched when its data has somewhere to land:
    // decode is taking words, or both the request slot and skid are empty.
    assign issue = !redirect
                 && (!stall || (!skid_valid_q && !req_valid_q));

    // Next-state: issue, output load / hold, skid capture, redirect flush.
    always_comb begin
        pc_d         = pc_q;
        req_valid_d  = req_valid_q;
        req_pc_d     = req_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        valid_d      = valid_q;

        if (redirect) begin
            pc_d         = redirect_pc;
            req_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            valid_d      = 1'b0;
        end else begin
            if (issue) begin
                req_pc_d    = pc_q;
                req_valid_d = 1'b1;
                pc_d        = pc_q + 32'd1;
            end else begin
                req_valid_d = 1'b0;
            end

            if (!stall) begin
                skid_valid_d = 1'b0;
                if (skid_valid_q) begin
                    instr_d = skid_instr_q;
                    opc_d   = skid_pc_q;
                    valid_d = 1'b1;
                end else if (req_valid_q) begin
                    instr_d = imem_q;
                    opc_d   = req_pc_q;
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (req_valid_q) begin
                skid_instr_d = imem_q;
                skid_pc_d    = req_pc_q;
                skid_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset that drops everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= '0;
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            instr_q      <= '0;
            opc_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
            valid_q      <= valid_d;
        end
    end

endmodule
